// File: rtl/ysyx_22051468_pkg.sv
// ysyx_22051468_pkg: shared writeback constants and long-result buffer state
package ysyx_22051468_pkg;
    localparam int WIDTH        = 64;
    localparam int REG_W        = 5;
    localparam int REG_NUM      = 32;
    localparam int STARVE_LIMIT = 4;
    typedef enum logic {WB_EMPTY, WB_HELD} wb_state_e;
endpackage

// File: rtl/ysyx_22051468_scoreboard.sv
// ysyx_22051468_scoreboard: per-register busy bits for outstanding long ops and the decode hazard
module ysyx_22051468_scoreboard #(
    parameter int REG_W   = ysyx_22051468_pkg::REG_W,
    parameter int REG_NUM = ysyx_22051468_pkg::REG_NUM
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_valid,
    input  logic             iss_long,
    input  logic [REG_W-1:0] iss_rd,
    input  logic [REG_W-1:0] iss_rs1,
    input  logic [REG_W-1:0] iss_rs2,
    input  logic             clr,
    input  logic [REG_W-1:0] clr_rd,
    output logic             hazard
);
    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] set_mask;
    logic [REG_NUM-1:0] clr_mask;
    always_comb begin
        hazard   = iss_valid && (busy[iss_rs1] || busy[iss_rs2] || busy[iss_rd]);
        set_mask = (iss_valid && !hazard && iss_long) ? (REG_NUM'(1) << iss_rd) : '0;
        clr_mask = clr ? (REG_NUM'(1) << clr_rd) : '0;
    end
    // bit 0 is masked so x0 never reads as busy
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) busy <= '0;
        else        busy <= (busy | set_mask) & ~clr_mask & ~REG_NUM'(1);
endmodule

// File: rtl/ysyx_22051468_wb_unit.sv
// ysyx_22051468_wb_unit: GPR writeback merging ALU and buffered long results; WB_PERF_CNT_EN adds perf counters
module ysyx_22051468_wb_unit
    import ysyx_22051468_pkg::*;
#(
    parameter int WIDTH        = ysyx_22051468_pkg::WIDTH,
    parameter int REG_W        = ysyx_22051468_pkg::REG_W,
    parameter int REG_NUM      = ysyx_22051468_pkg::REG_NUM,
    parameter int STARVE_LIMIT = ysyx_22051468_pkg::STARVE_LIMIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_valid_i,
    input  logic             iss_long_i,
    input  logic [REG_W-1:0] iss_rd_i,
    input  logic [REG_W-1:0] iss_rs1_i,
    input  logic [REG_W-1:0] iss_rs2_i,
    output logic             hazard_o,
    input  logic             alu_valid_i,
    input  logic [REG_W-1:0] alu_rd_i,
    input  logic [WIDTH-1:0] alu_data_i,
    input  logic             lsu_valid_i,
    output logic             lsu_ready_o,
    input  logic [REG_W-1:0] lsu_rd_i,
    input  logic [WIDTH-1:0] lsu_data_i,
    output logic             starve_o,
`ifdef WB_PERF_CNT_EN
    output logic [63:0]      perf_wr_cnt_o,
    output logic [63:0]      perf_defer_cnt_o,
`endif
    output logic [REG_W-1:0] rd_waddr_o,
    output logic [WIDTH-1:0] rd_wdata_o,
    output logic             wen_o
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    wb_state_e        state, state_nxt;
    logic [REG_W-1:0] buf_rd, sel_rd;
    logic [WIDTH-1:0] buf_data, sel_data;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             drain, deferred, sel_valid, wr;
    always_comb begin
        lsu_ready_o = state == WB_EMPTY;
        drain       = state == WB_HELD && !alu_valid_i;
        deferred    = state == WB_HELD && alu_valid_i;
        state_nxt   = lsu_ready_o ? (lsu_valid_i ? WB_HELD : WB_EMPTY)
                                  : (alu_valid_i ? WB_HELD : WB_EMPTY);
        sel_valid   = alu_valid_i || drain;
        sel_rd      = alu_valid_i ? alu_rd_i : buf_rd;
        sel_data    = alu_valid_i ? alu_data_i : buf_data;
        wr          = sel_valid && sel_rd != '0;
        cnt_nxt     = drain ? '0 : (deferred && cnt != CW'(STARVE_LIMIT)) ? cnt + 1'b1 : cnt;
    end
    ysyx_22051468_scoreboard #(.REG_W(REG_W), .REG_NUM(REG_NUM)) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid_i),
        .iss_long  (iss_long_i),
        .iss_rd    (iss_rd_i),
        .iss_rs1   (iss_rs1_i),
        .iss_rs2   (iss_rs2_i),
        .clr       (drain),
        .clr_rd    (buf_rd),
        .hazard    (hazard_o)
    );
    // starve_o is derived from the next count so it lines up with the counter itself
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= WB_EMPTY;
            buf_rd     <= '0;
            buf_data   <= '0;
            cnt        <= '0;
            starve_o   <= 1'b0;
            wen_o      <= 1'b0;
            rd_waddr_o <= '0;
            rd_wdata_o <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            starve_o <= cnt_nxt >= CW'(STARVE_LIMIT);
            wen_o    <= wr;
            if (lsu_ready_o && lsu_valid_i) begin
                buf_rd   <= lsu_rd_i;
                buf_data <= lsu_data_i;
            end
            if (wr) begin
                rd_waddr_o <= sel_rd;
                rd_wdata_o <= sel_data;
            end
        end
`ifdef WB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            perf_wr_cnt_o    <= '0;
            perf_defer_cnt_o <= '0;
        end else begin
            perf_wr_cnt_o    <= perf_wr_cnt_o + 64'(wen_o);
            perf_defer_cnt_o <= perf_defer_cnt_o + 64'(deferred);
        end
`endif
endmodule

// File: tb/tb_ysyx_22051468_wb_unit.sv
// tb_ysyx_22051468_wb_unit: scenario tasks with a write-port scoreboard queue
module tb_ysyx_22051468_wb_unit;
    logic        clk, rst_n;
    logic        iss_valid, iss_long, alu_valid, lsu_valid;
    logic [4:0]  iss_rd, iss_rs1, iss_rs2, alu_rd, lsu_rd;
    logic [63:0] alu_data, lsu_data;
    logic        hazard, lsu_ready, starve, wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [68:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    ysyx_22051468_wb_unit dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid_i(iss_valid), .iss_long_i(iss_long), .iss_rd_i(iss_rd),
        .iss_rs1_i(iss_rs1), .iss_rs2_i(iss_rs2), .hazard_o(hazard),
        .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_rd_i(lsu_rd),
        .lsu_data_i(lsu_data), .starve_o(starve),
        .rd_waddr_o(waddr), .rd_wdata_o(wdata), .wen_o(wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // every write on the port must match the oldest expected write
    always @(negedge clk) if (wen === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL wr_unexpected: got rd=%0d data=%h, expected no write", waddr, wdata);
        end else begin
            logic [68:0] e;
            e = exp_q.pop_front();
            if ({waddr, wdata} !== e) begin
                fails++;
                $display("FAIL wr_data: got rd=%0d data=%h, expected rd=%0d data=%h", waddr, wdata, e[68:64], e[63:0]);
            end
        end
    end

    task automatic idle();
        iss_valid = 0; iss_long = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
        alu_valid = 0; alu_rd = 0; alu_data = '0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = '0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [63:0] d);
        alu_valid = 1; alu_rd = rd; alu_data = d;
        if (rd != 0) exp_q.push_back({rd, d});
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        repeat (2) @(negedge clk);
        iss_valid = 1; iss_rs1 = 3; iss_rs2 = 4; iss_rd = 5;
        #1;
        tests++;
        if ({wen, waddr, wdata, starve, lsu_ready, hazard} !== {1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset: got wen=%b addr=%0d data=%h starve=%b ready=%b hazard=%b", wen, waddr, wdata, starve, lsu_ready, hazard);
        end
        @(negedge clk);
        idle();
        rst_n = 1;
    endtask

    task automatic test_alu_write();
        @(negedge clk); alu(5, 64'hDEAD);
        @(negedge clk); idle();
        @(negedge clk);
    endtask

    task automatic test_x0();
        @(negedge clk); alu(0, 64'h1234);
        @(negedge clk); idle();
        tests++;
        if (wen !== 1'b0) begin fails++; $display("FAIL x0_alu_wen: got %b, expected 0", wen); end
        lsu_valid = 1; lsu_rd = 0; lsu_data = 64'h5555;
        #1;
        tests++;
        if (lsu_ready !== 1'b1) begin fails++; $display("FAIL x0_lsu_ready: got %b, expected 1", lsu_ready); end
        @(negedge clk); idle();
        @(negedge clk);
        tests++;
        if (wen !== 1'b0 || lsu_ready !== 1'b1) begin
            fails++;
            $display("FAIL x0_lsu_drain: got wen=%b ready=%b, expected wen=0 ready=1", wen, lsu_ready);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        iss_valid = 1; iss_long = 1; iss_rd = 7; iss_rs1 = 1; iss_rs2 = 2;
        #1;
        tests++;
        if (hazard !== 1'b0) begin fails++; $display("FAIL sb_issue: got hazard=%b, expected 0", hazard); end
        @(negedge clk);
        iss_long = 0; iss_rd = 3; iss_rs1 = 7; iss_rs2 = 4;
        #1;
        tests++;
        if (hazard !== 1'b1) begin fails++; $display("FAIL sb_raw_rs1: got hazard=%b, expected 1", hazard); end
        iss_rs1 = 4; iss_rs2 = 7;
        #1;
        tests++;
        if (hazard !== 1'b1) begin fails++; $display("FAIL sb_raw_rs2: got hazard=%b, expected 1", hazard); end
        iss_rs2 = 4; iss_rd = 7;
        #1;
        tests++;
        if (hazard !== 1'b1) begin fails++; $display("FAIL sb_waw: got hazard=%b, expected 1", hazard); end
        iss_valid = 0;
        #1;
        tests++;
        if (hazard !== 1'b0) begin fails++; $display("FAIL sb_gated: got hazard=%b, expected 0", hazard); end
        @(negedge clk);
        iss_valid = 1; iss_rd = 0; iss_rs1 = 7; iss_rs2 = 0;
        lsu_valid = 1; lsu_rd = 7; lsu_data = 64'h7777_0000_7777;
        exp_q.push_back({5'd7, 64'h7777_0000_7777});
        @(negedge clk);
        lsu_valid = 0;
        #1;
        tests++;
        if (hazard !== 1'b1) begin fails++; $display("FAIL sb_held_busy: got hazard=%b, expected 1", hazard); end
        @(negedge clk);
        #1;
        tests++;
        if (hazard !== 1'b0 || wen !== 1'b1) begin
            fails++;
            $display("FAIL sb_cleared: got hazard=%b wen=%b, expected hazard=0 wen=1", hazard, wen);
        end
        idle();
    endtask

    task automatic test_collision();
        @(negedge clk);
        alu(10, 64'hA);
        lsu_valid = 1; lsu_rd = 11; lsu_data = 64'hB;
        #1;
        tests++;
        if (lsu_ready !== 1'b1) begin fails++; $display("FAIL col_ready0: got %b, expected 1", lsu_ready); end
        @(negedge clk);
        lsu_valid = 0;
        alu(12, 64'hC);
        #1;
        tests++;
        if (lsu_ready !== 1'b0) begin fails++; $display("FAIL col_ready1: got %b, expected 0", lsu_ready); end
        @(negedge clk);
        idle();
        exp_q.push_back({5'd11, 64'hB});
        repeat (2) @(negedge clk);
        tests++;
        if (lsu_ready !== 1'b1) begin fails++; $display("FAIL col_ready_end: got %b, expected 1", lsu_ready); end
    endtask

    task automatic test_starve();
        @(negedge clk);
        lsu_valid = 1; lsu_rd = 13; lsu_data = 64'hD;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (starve !== 1'b0) begin fails++; $display("FAIL starve_early%0d: got %b, expected 0", i, starve); end
            lsu_valid = 0;
            alu(5'(14 + i), 64'(100 + i));
        end
        @(negedge clk);
        tests++;
        if (starve !== 1'b1) begin fails++; $display("FAIL starve_set: got %b, expected 1", starve); end
        idle();
        exp_q.push_back({5'd13, 64'hD});
        @(negedge clk);
        tests++;
        if (starve !== 1'b0) begin fails++; $display("FAIL starve_clear: got %b, expected 0", starve); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        lsu_valid = 1; lsu_rd = 25; lsu_data = 64'hFACE;
        for (int i = 0; i < 8; i++) begin
            alu(5'($urandom_range(1, 31)), {$urandom, $urandom});
            @(negedge clk);
            lsu_valid = 0;
        end
        idle();
        exp_q.push_back({5'd25, 64'hFACE});
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        iss_valid = 1; iss_long = 1; iss_rd = 9;
        @(negedge clk);
        idle();
        lsu_valid = 1; lsu_rd = 20; lsu_data = 64'h20;
        @(negedge clk);
        lsu_valid = 0;
        alu(21, 64'h21);
        @(negedge clk);
        alu_valid = 1; alu_rd = 22; alu_data = 64'h22;
        iss_valid = 1; iss_rs1 = 9;
        #1;
        tests++;
        if (hazard !== 1'b1 || lsu_ready !== 1'b0) begin
            fails++;
            $display("FAIL arst_setup: got hazard=%b ready=%b, expected hazard=1 ready=0", hazard, lsu_ready);
        end
        #1 rst_n = 0;
        #1;
        tests++;
        if ({wen, waddr, wdata, starve, lsu_ready, hazard} !== {1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL arst: got wen=%b addr=%0d data=%h starve=%b ready=%b hazard=%b", wen, waddr, wdata, starve, lsu_ready, hazard);
        end
        @(negedge clk);
        idle();
        rst_n = 1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_x0();
        test_scoreboard();
        test_collision();
        test_starve();
        test_back_to_back();
        test_async_reset();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_writes: got %0d still pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ysyx_22051468_wb_unit.md
Name: ysyx_22051468_wb_unit

Overview:
Writeback stage driving the GPR file write port (rd address, rd data, write enable).
- Merges single-cycle ALU results with long-latency results (LSU/MDU) returned over a valid/ready handshake.
- Keeps a per-register busy scoreboard so decode stalls on RAW/WAW hazards against outstanding long ops.
- Sits between exec/LSU and the GPR file; its hazard output feeds the decode stage.

Parameters:
- WIDTH, 64, GPR data width.
- REG_W, 5, register address width.
- REG_NUM, 32, number of GPRs.
- STARVE_LIMIT, 4, consecutive cycles a buffered long result may be deferred before starve_o asserts.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- iss_valid_i  in  1  decode presents an instruction this cycle.
- iss_long_i  in  1  instruction goes to the long-latency unit.
- iss_rd_i  in  REG_W  destination register.
- iss_rs1_i  in  REG_W  source 1.
- iss_rs2_i  in  REG_W  source 2.
- hazard_o  out  1  decode must hold; issue not accepted.
- alu_valid_i  in  1  ALU result valid; cannot be back-pressured.
- alu_rd_i  in  REG_W  ALU destination.
- alu_data_i  in  WIDTH  ALU result.
- lsu_valid_i  in  1  long result valid.
- lsu_ready_o  out  1  long result accepted when valid and ready.
- lsu_rd_i  in  REG_W  long destination.
- lsu_data_i  in  WIDTH  long result.
- starve_o  out  1  request upstream to insert one ALU bubble.
- rd_waddr_o  out  REG_W  GPR write address (registered).
- rd_wdata_o  out  WIDTH  GPR write data (registered).
- wen_o  out  1  GPR write enable (registered).

Behaviour:
- Reset (async, rst_n=0): busy[] = 0, buffer EMPTY, defer counter = 0, wen_o = 0, rd_waddr_o = 0, rd_wdata_o = 0, starve_o = 0.
- Reset asserted mid-operation discards the buffered result and all outstanding busy bits.

Scoreboard:
- hazard_o = busy[iss_rs1_i] | busy[iss_rs2_i] | busy[iss_rd_i]. This is combinational and gated by iss_valid_i.
- busy[0] is constant 0.
- An issue is accepted when iss_valid_i & !hazard_o.
- An accepted issue with iss_long_i=1 and iss_rd_i≠0 sets busy[iss_rd_i] at the next edge.
- busy[r] clears at the edge where the long result for r is driven onto the write port.
- Set and clear of the same r in one cycle cannot occur, because the issue is blocked by the WAW term.

Long-result buffer (FSM EMPTY/HELD):
- lsu_ready_o = (state == EMPTY).
- EMPTY→HELD on lsu_valid_i: captures rd and data.
- HELD→EMPTY on the cycle alu_valid_i=0 (drain).
- An ALU result always has priority over the buffer.

Write port (1-cycle latency, registered):
- Cycle N: alu_valid_i, or a buffer drain, → edge N+1: wen_o, rd_waddr_o, rd_wdata_o.
- wen_o is forced to 0 when the selected rd is 0. A long result to x0 is still consumed and drained.
- When there is no write, wen_o = 0. rd_waddr_o and rd_wdata_o hold their last values.

Starvation:
- The defer counter increments each cycle the state is HELD and alu_valid_i=1. It resets on drain.
- starve_o = (counter ≥ STARVE_LIMIT), registered.
- Upstream must deassert alu_valid_i for at least one cycle while starve_o is high.

Optional Feature:
WB_PERF_CNT_EN:
- When defined, adds two output ports:
  - perf_wr_cnt_o [63:0]: count of wen_o=1 cycles.
  - perf_defer_cnt_o [63:0]: count of HELD cycles with alu_valid_i=1.
- Both counters reset to 0 and wrap modulo 2^64.
- When not defined, these ports and counters do not exist.

Decomposition:
- Shared package ysyx_22051468_pkg holds:
  - REG_W, REG_NUM, WIDTH constants.
  - the buffer state enum {WB_EMPTY, WB_HELD}.
- One sub-module is natural: ysyx_22051468_scoreboard, containing the busy[] vector, the set/clear logic, and the hazard_o computation.

Test Plan:
- ALU write: alu_valid_i=1, rd=5, data=0xDEAD → next cycle wen_o=1, rd_waddr_o=5, rd_wdata_o=0xDEAD.
- x0 suppression: alu_valid_i=1 with rd=0 → wen_o=0. A long result to rd=0 is accepted (lsu_ready_o=1) and produces no write.
- Scoreboard:
  - Issue long with rd=7 → busy[7] set.
  - Issue with rs1=7 → hazard_o=1.
  - Long result rd=7 returned and drained → hazard_o=0 on the cycle after the write.
- Collision: alu_valid_i and lsu_valid_i in the same cycle → ALU written first, lsu_ready_o=0 the following cycle, long result written the first cycle alu_valid_i=0.
- Starvation: HELD with alu_valid_i=1 for 4 cycles (STARVE_LIMIT=4) → starve_o=1. One bubble → drain, then starve_o=0.
- Async reset while HELD with busy[9] set → all outputs 0 immediately, lsu_ready_o=1, hazard_o=0 for rs1=9.
